// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared state encoding and bus constants for the I2C responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX        = 3'd3,
        RX_ACK    = 3'd4,
        TX        = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_slv_state_t;

    localparam logic       RW_WRITE         = 1'b0;
    localparam logic       RW_READ          = 1'b1;
    localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ============================================================================
// Module      : i2c_sync_edge
// Description : Multi-flop synchronizer with a history flop producing
//               single-cycle rise/fall strobes for one bus line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Reset to the idle-high bus level so leaving reset creates no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
// ============================================================================
// Module      : i2c_slave
// Description : Oversampled I2C target with fixed 7-bit address, byte-stream
//               write output and byte-stream read input. No clock stretching.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       addr_hit
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst(rst), .i_in(scl),
        .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst(rst), .i_in(sda),
        .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    i2c_slv_state_t r_state, w_state_n;
    logic [7:0] r_shift, w_shift_n;
    logic [2:0] r_cnt, w_cnt_n;
    logic       r_rw, w_rw_n;
    logic       r_oe, w_oe_n;
    logic       r_phase, w_phase_n;
    logic [7:0] r_rx_data, w_rx_data_n;
    logic       r_rx_valid, w_rx_valid_n;
    logic       r_tx_req, w_tx_req_n;
    logic       r_busy, w_busy_n;
    logic       r_hit, w_hit_n;

    logic       w_start, w_stop;
    logic [7:0] w_byte;

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;
    assign w_byte  = {r_shift[6:0], w_sda_lvl};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_rw       <= RW_WRITE;
            r_oe       <= 1'b0;
            r_phase    <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_shift    <= w_shift_n;
            r_cnt      <= w_cnt_n;
            r_rw       <= w_rw_n;
            r_oe       <= w_oe_n;
            r_phase    <= w_phase_n;
            r_rx_data  <= w_rx_data_n;
            r_rx_valid <= w_rx_valid_n;
            r_tx_req   <= w_tx_req_n;
            r_busy     <= w_busy_n;
            r_hit      <= w_hit_n;
        end
    end

    // r_phase: in *_ACK it marks "ACK being driven"; in TX it marks
    // "first bit of a freshly loaded byte still pending".
    always_comb begin
        w_state_n    = r_state;
        w_shift_n    = r_shift;
        w_cnt_n      = r_cnt;
        w_rw_n       = r_rw;
        w_oe_n       = r_oe;
        w_phase_n    = r_phase;
        w_rx_data_n  = r_rx_data;
        w_rx_valid_n = 1'b0;
        w_tx_req_n   = 1'b0;
        w_busy_n     = r_busy;
        w_hit_n      = r_hit;

        if (r_tx_req) begin
            w_shift_n = tx_data;
        end

        if (w_start) begin
            w_state_n = ADDR;
            w_cnt_n   = '0;
            w_busy_n  = 1'b1;
            w_hit_n   = 1'b0;
            w_oe_n    = 1'b0;
            w_phase_n = 1'b0;
        end else if (w_stop) begin
            w_state_n = IDLE;
            w_busy_n  = 1'b0;
            w_hit_n   = 1'b0;
            w_oe_n    = 1'b0;
            w_phase_n = 1'b0;
        end else begin
            case (r_state)
                IDLE: w_oe_n = 1'b0;
                ADDR: if (w_scl_rise) begin
                    w_shift_n = w_byte;
                    w_cnt_n   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        if ((w_byte[7:1] == SLAVE_ADDR) && (w_byte[7:1] != I2C_GENERAL_CALL)) begin
                            w_state_n  = ADDR_ACK;
                            w_hit_n    = 1'b1;
                            w_rw_n     = w_byte[0];
                            w_phase_n  = 1'b0;
                            w_tx_req_n = (w_byte[0] == RW_READ);
                        end else begin
                            w_state_n = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_oe_n    = 1'b1;
                        w_phase_n = 1'b1;
                    end else if (r_rw == RW_WRITE) begin
                        w_oe_n    = 1'b0;
                        w_phase_n = 1'b0;
                        w_cnt_n   = '0;
                        w_state_n = RX;
                    end else begin
                        w_oe_n    = ~r_shift[7];
                        w_shift_n = {r_shift[6:0], 1'b0};
                        w_cnt_n   = 3'd1;
                        w_phase_n = 1'b0;
                        w_state_n = TX;
                    end
                end
                RX: if (w_scl_rise) begin
                    w_shift_n = w_byte;
                    w_cnt_n   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_rx_data_n  = w_byte;
                        w_rx_valid_n = 1'b1;
                        w_phase_n    = 1'b0;
                        w_state_n    = RX_ACK;
                    end
                end
                RX_ACK: if (w_scl_fall) begin
                    w_oe_n    = ~r_phase;
                    w_phase_n = ~r_phase;
                    if (r_phase) begin
                        w_state_n = RX;
                    end
                end
                TX: if (w_scl_fall) begin
                    if (r_phase || (r_cnt != 3'd0)) begin
                        w_oe_n    = ~r_shift[7];
                        w_shift_n = {r_shift[6:0], 1'b0};
                        w_cnt_n   = r_cnt + 3'd1;
                        w_phase_n = 1'b0;
                    end else begin
                        w_oe_n    = 1'b0;
                        w_state_n = TX_ACK;
                    end
                end
                TX_ACK: if (w_scl_rise) begin
                    if (!w_sda_lvl) begin
                        w_tx_req_n = 1'b1;
                        w_cnt_n    = '0;
                        w_phase_n  = 1'b1;
                        w_state_n  = TX;
                    end else begin
                        w_state_n = WAIT_STOP;
                    end
                end
                WAIT_STOP: w_oe_n = 1'b0;
                default:   w_state_n = IDLE;
            endcase
        end
    end

    assign sda      = r_oe ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;
    assign addr_hit = r_hit;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ============================================================================
// Module      : tb_i2c_slave
// Description : Bit-banged I2C master with scoreboard queues for the responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       r_scl;
    logic       r_m_drv;
    logic [7:0] r_tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       addr_hit;
    wire        sda;

    pullup (sda);
    assign sda = r_m_drv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(r_scl), .sda(sda),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(r_tx_data),
        .tx_req(tx_req), .busy(busy), .addr_hit(addr_hit)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt  = 0;
    int tx_cnt  = 0;
    int dut_low = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (rx_valid || tx_req)) begin
            chk("rxv_txr_excl", {31'b0, rx_valid & tx_req}, 32'd0);
        end
        if (rx_valid) begin
            rx_cnt++;
            if (exp_rx_q.size() == 0) chk("rx_unexpected", {24'b0, rx_data}, 32'hFFFF_FFFF);
            else                      chk("rx_data", {24'b0, rx_data}, {24'b0, exp_rx_q.pop_front()});
        end
        if (tx_req) begin
            tx_cnt++;
            exp_tx_q.push_back(r_tx_data);
        end
        if (!r_m_drv && sda === 1'b0) dut_low++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(4); r_m_drv = ~b;
        wait_clk(4); r_scl = 1'b1;
        wait_clk(8); r_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(4); r_m_drv = 1'b0;
        wait_clk(4); r_scl = 1'b1;
        wait_clk(4); b = sda;
        wait_clk(4); r_scl = 1'b0;
    endtask

    task automatic bus_start();
        if (!r_scl) begin
            wait_clk(4); r_m_drv = 1'b0;
            wait_clk(4); r_scl = 1'b1;
        end
        wait_clk(4); r_m_drv = 1'b1;
        wait_clk(4); r_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(4); r_m_drv = 1'b1;
        wait_clk(4); r_scl = 1'b1;
        wait_clk(4); r_m_drv = 1'b0;
        wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic recv8(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) recv_bit(b[i]);
    endtask

    task automatic chk_tx(input string tag, input logic [7:0] got);
        if (exp_tx_q.size() == 0) chk(tag, {24'b0, got}, 32'hFFFF_FFFF);
        else                      chk(tag, {24'b0, got}, {24'b0, exp_tx_q.pop_front()});
    endtask

    initial begin : main
        logic       ack;
        logic [7:0] b;
        int         base_rx, base_tx, base_low;

        rst = 1'b1; r_scl = 1'b1; r_m_drv = 1'b0; r_tx_data = 8'h00;
        wait_clk(5);
        chk("rst_sda", {31'b0, sda}, 32'd1);
        chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("rst_tx_req", {31'b0, tx_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hit", {31'b0, addr_hit}, 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // Write transfer
        base_rx = rx_cnt;
        bus_start();
        chk("wr_busy", {31'b0, busy}, 32'd1);
        send_byte(8'h54, ack);
        chk("wr_addr_ack", {31'b0, ack}, 32'd0);
        chk("wr_hit", {31'b0, addr_hit}, 32'd1);
        exp_rx_q.push_back(8'hA5);
        send_byte(8'hA5, ack);
        chk("wr_d0_ack", {31'b0, ack}, 32'd0);
        exp_rx_q.push_back(8'h3C);
        send_byte(8'h3C, ack);
        chk("wr_d1_ack", {31'b0, ack}, 32'd0);
        chk("wr_busy_mid", {31'b0, busy}, 32'd1);
        bus_stop();
        chk("wr_busy_end", {31'b0, busy}, 32'd0);
        chk("wr_hit_end", {31'b0, addr_hit}, 32'd0);
        chk("wr_rx_cnt", rx_cnt - base_rx, 32'd2);

        // Read transfer: ACK first byte, NACK second
        base_tx = tx_cnt;
        r_tx_data = 8'h96;
        bus_start();
        send_byte(8'h55, ack);
        chk("rd_addr_ack", {31'b0, ack}, 32'd0);
        recv8(b);
        chk_tx("rd_d0", b);
        r_tx_data = 8'h0F;
        send_bit(1'b0);
        recv8(b);
        chk_tx("rd_d1", b);
        r_tx_data = 8'h00;
        send_bit(1'b1);
        wait_clk(4);
        chk("rd_release", {31'b0, sda}, 32'd1);
        bus_stop();
        chk("rd_tx_cnt", tx_cnt - base_tx, 32'd2);

        // Address mismatch
        base_rx = rx_cnt; base_low = dut_low;
        bus_start();
        send_byte(8'h56, ack);
        chk("mm_addr_nack", {31'b0, ack}, 32'd1);
        chk("mm_hit", {31'b0, addr_hit}, 32'd0);
        send_byte(8'hFF, ack);
        chk("mm_data_nack", {31'b0, ack}, 32'd1);
        bus_stop();
        chk("mm_no_drive", dut_low - base_low, 32'd0);
        chk("mm_no_rx", rx_cnt - base_rx, 32'd0);

        // Repeated START: write then read
        base_tx = tx_cnt;
        bus_start();
        send_byte(8'h54, ack);
        chk("rs_wr_ack", {31'b0, ack}, 32'd0);
        exp_rx_q.push_back(8'h11);
        send_byte(8'h11, ack);
        chk("rs_d_ack", {31'b0, ack}, 32'd0);
        r_tx_data = 8'h77;
        bus_start();
        send_byte(8'h55, ack);
        chk("rs_rd_ack", {31'b0, ack}, 32'd0);
        recv8(b);
        chk_tx("rs_rd_data", b);
        send_bit(1'b1);
        bus_stop();
        chk("rs_rx_data", {24'b0, rx_data}, 32'h11);
        chk("rs_tx_cnt", tx_cnt - base_tx, 32'd1);
        chk("rs_idle", {29'b0, dut.r_state}, 32'd0);

        // STOP in the middle of a data byte, then a normal transfer
        base_rx = rx_cnt;
        bus_start();
        send_byte(8'h54, ack);
        chk("ps_addr_ack", {31'b0, ack}, 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_stop();
        chk("ps_no_rx", rx_cnt - base_rx, 32'd0);
        chk("ps_busy", {31'b0, busy}, 32'd0);
        chk("ps_sda", {31'b0, sda}, 32'd1);
        bus_start();
        send_byte(8'h54, ack);
        chk("ps2_addr_ack", {31'b0, ack}, 32'd0);
        exp_rx_q.push_back(8'hC3);
        send_byte(8'hC3, ack);
        chk("ps2_d_ack", {31'b0, ack}, 32'd0);
        bus_stop();
        chk("ps2_rx", rx_cnt - base_rx, 32'd1);

        // Reset while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(b_addr(i));
        r_m_drv = 1'b0;
        wait_clk(4);
        chk("ra_ack_low", {31'b0, sda}, 32'd0);
        rst = 1'b1;
        wait_clk(1);
        chk("ra_sda", {31'b0, sda}, 32'd1);
        chk("ra_busy", {31'b0, busy}, 32'd0);
        chk("ra_hit", {31'b0, addr_hit}, 32'd0);
        chk("ra_rx_data", {24'b0, rx_data}, 32'd0);
        chk("ra_flags", {30'b0, rx_valid, tx_req}, 32'd0);
        rst = 1'b0;
        wait_clk(4); r_scl = 1'b1;
        wait_clk(8);

        chk("rx_q_empty", exp_rx_q.size(), 32'd0);
        chk("tx_q_empty", exp_tx_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic b_addr(input int i);
        logic [7:0] v;
        v = 8'h54;
        return v[i];
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
